cfg_serial_rx: RTL and testbench

Serial configuration receiver for the deskew IP. It deserializes write frames from an external 3-wire host interface (chip select, serial clock, serial data), all asynchronous to `clk`. For each valid write it issues a one-cycle `write_en` strobe with address, data and `set` bit. It sits directly upstream of the per-register config wrappers, which compare the address and generate their own pulses; its outputs fan out to all of them.

---
 rtl/cfg_serial_rx.sv | 135 +++++++++++++
 tb/tb_cfg_serial_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cfg_serial_rx.sv
// Serial configuration receiver: deserializes cs_n/sclk/sdi write frames from an
// asynchronous 3-wire host and issues a one-cycle write strobe per valid frame.
module cfg_serial_rx #(
    parameter int unsigned REG_ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cs_n_in,
    input  logic                      sclk_in,
    input  logic                      sdi_in,
    output logic [REG_ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      set,
    output logic                      write_en,
    output logic                      frame_err
);

    localparam int unsigned FRAME_LEN = 1 + REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_MAX   = FRAME_LEN + 1;
    localparam int unsigned CNT_TOP   = (CNT_MAX > SYNC_STAGES) ? CNT_MAX : SYNC_STAGES;
    localparam int unsigned CNT_W     = $clog2(CNT_TOP + 1);

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;

    logic [SYNC_STAGES-1:0]    cs_sync_q, sclk_sync_q, sdi_sync_q;
    logic                      sclk_dly_q;
    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]      shift_q, shift_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      we_q, we_d;
    logic                      err_q, err_d;
    logic                      cs_s, sdi_s, sclk_rise;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;

    // Input synchronizers and sclk edge-detect delay flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            sclk_dly_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_in};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            // The cs_n chain's reset value is not a real sample, so let the
            // synchronizer fill before trusting it; a frame in flight is dropped.
            ST_WAIT_IDLE: begin
                if (cnt_q < CNT_W'(SYNC_STAGES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (cs_s) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!cs_s) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // cs_n rise takes priority over a coincident sclk rise
                if (cs_s) begin
                    state_d = ST_IDLE;
                    if (cnt_q == CNT_W'(FRAME_LEN)) begin
                        if (shift_q[FRAME_LEN-1]) begin
                            addr_d = shift_q[FRAME_LEN-2 -: REG_ADDR_WIDTH];
                            data_d = shift_q[DATA_WIDTH-1:0];
                            we_d   = 1'b1;
                        end
                    end else if (cnt_q != '0) begin
                        err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_LEN-2:0], sdi_s};
                    if (cnt_q != CNT_W'(CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    assign addr_out  = addr_q;
    assign data_out  = data_q;
    assign set       = data_q[0];
    assign write_en  = we_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_cfg_serial_rx.sv
// Directed bench for cfg_serial_rx: drives host frames, predicts the outcome of
// each frame into a queue and compares strobes and outputs as they appear.
module tb_cfg_serial_rx;

    localparam int unsigned FL = 17;

    logic       clk = 1'b0;
    logic       rst_n, cs_n, sclk, sdi;
    logic [7:0] addr_out, data_out;
    logic       set, write_en, frame_err;

    typedef struct {
        int         kind;   // 0 none, 1 write, 2 frame error
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_data = 8'h00;
    int         checks = 0;
    int         errors = 0;

    cfg_serial_rx #(.REG_ADDR_WIDTH(8), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n_in  (cs_n),
        .sclk_in  (sclk),
        .sdi_in   (sdi),
        .addr_out (addr_out),
        .data_out (data_out),
        .set      (set),
        .write_en (write_en),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        sclk = 1'b0;
        wait_neg(4);
    endtask

    // MSB first: v[n-1] is the first bit on the wire
    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 1'b0;
            sdi  = v[i];
            wait_neg(4);
            sclk = 1'b1;
            wait_neg(4);
        end
    endtask

    task automatic push_expect(input logic [63:0] v, input int n, input bit coinc);
        exp_t       e;
        int         eff;
        logic [63:0] ve;
        eff    = coinc ? n - 1 : n;
        ve     = coinc ? (v >> 1) : v;
        e.kind = 0;
        if (eff == FL) begin
            if (ve[16]) begin
                m_addr = ve[15:8];
                m_data = ve[7:0];
                e.kind = 1;
            end
        end else if (eff != 0) begin
            e.kind = 2;
        end
        e.addr = m_addr;
        e.data = m_data;
        exp_q.push_back(e);
    endtask

    // Called right after cs_n rises on a negedge; sample i=0 follows edge N
    task automatic check_frame(input string tag);
        exp_t e;
        int   we_n = 0, err_n = 0, we_at = -1, err_at = -1;
        if (exp_q.size() == 0) begin
            chk({tag, " queue"}, 32'(0), 32'(1));
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (write_en === 1'b1) begin we_n++; we_at = i; end
            if (frame_err === 1'b1) begin err_n++; err_at = i; end
        end
        chk({tag, " we_count"},  32'(we_n),  32'((e.kind == 1) ? 1 : 0));
        chk({tag, " err_count"}, 32'(err_n), 32'((e.kind == 2) ? 1 : 0));
        if (e.kind == 1) chk({tag, " we_cycle"},  32'(we_at),  32'(2));
        if (e.kind == 2) chk({tag, " err_cycle"}, 32'(err_at), 32'(2));
        chk({tag, " addr"}, 32'(addr_out), 32'(e.addr));
        chk({tag, " data"}, 32'(data_out), 32'(e.data));
        chk({tag, " set"},  32'(set),      32'(e.data[0]));
        @(negedge clk);
    endtask

    task automatic frame(input string tag, input logic [63:0] v, input int n, input bit coinc);
        cs_low();
        if (coinc) begin
            send_bits(v >> 1, n - 1);
            sclk = 1'b0;
            sdi  = v[0];
            wait_neg(4);
            sclk = 1'b1;
            cs_n = 1'b1;
        end else begin
            send_bits(v, n);
            cs_n = 1'b1;
        end
        push_expect(v, n, coinc);
        check_frame(tag);
    endtask

    initial begin
        logic [63:0] v;
        exp_t        e;
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        sdi   = 1'b0;
        wait_neg(3);
        chk("reset addr",  32'(addr_out),  32'(0));
        chk("reset data",  32'(data_out),  32'(0));
        chk("reset set",   32'(set),       32'(0));
        chk("reset we",    32'(write_en),  32'(0));
        chk("reset err",   32'(frame_err), 32'(0));
        rst_n = 1'b1;
        wait_neg(6);

        frame("wr05", 64'({1'b1, 8'h05, 8'h01}), 17, 1'b0);
        frame("short16", 64'({1'b1, 8'h05, 7'h2A}), 16, 1'b0);
        frame("long18", 64'({1'b1, 8'h33, 8'h44, 1'b1}), 18, 1'b0);
        v = {$urandom, $urandom};
        frame("long40", v | 64'h80_0000_0000, 40, 1'b0);
        frame("read22", 64'({1'b0, 8'h22, 8'h5A}), 17, 1'b0);

        // Reset in the middle of a frame, then finish the frame with cs_n held low
        v = 64'({1'b1, 8'h77, 8'h99});
        cs_low();
        send_bits(v >> 11, 6);
        rst_n = 1'b0;
        #1;
        chk("midrst addr", 32'(addr_out),  32'(0));
        chk("midrst data", 32'(data_out),  32'(0));
        chk("midrst we",   32'(write_en),  32'(0));
        chk("midrst err",  32'(frame_err), 32'(0));
        m_addr = 8'h00;
        m_data = 8'h00;
        wait_neg(2);
        rst_n = 1'b1;
        send_bits(v, 11);
        cs_n   = 1'b1;
        e.kind = 0;
        e.addr = m_addr;
        e.data = m_data;
        exp_q.push_back(e);
        check_frame("midrst tail");

        frame("wrA3", 64'({1'b1, 8'hA3, 8'hFE}), 17, 1'b0);
        frame("b2b1", 64'({1'b1, 8'h01, 8'h01}), 17, 1'b0);
        frame("b2b2", 64'({1'b1, 8'h02, 8'h00}), 17, 1'b0);
        frame("coinc", 64'({1'b1, 8'h44, 8'h55}), 17, 1'b1);

        chk("queue empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
